mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_if.sv | 37 +++
 rtl/mem_arb_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        ID_IF = 1'b0,
        ID_D  = 1'b1
    } req_id_e;

    function automatic req_id_e other_id(input req_id_e id);
        return (id == ID_IF) ? ID_D : ID_IF;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter; master = requesters/memory, slave = arbiter.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: a lone requester wins, a tie goes to the pointer's id.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    if_req_i,
    input  logic    d_req_i,
    input  req_id_e ptr_i,
    output logic    any_c_o,
    output req_id_e win_c_o
);
    always_comb begin
        any_c_o = if_req_i | d_req_i;
        win_c_o = ptr_i;
        if (if_req_i && !d_req_i) begin
            win_c_o = ID_IF;
        end else if (d_req_i && !if_req_i) begin
            win_c_o = ID_D;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port memory: IDLE -> ACCESS -> RESP, fixed 3-cycle access.
// MEM_ARB_RR_EN selects round-robin tie-break; default build gives the data port fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    state_e            state_q, state_d;
    req_id_e           id_q, id_d;
    req_id_e           ptr_c;
    req_id_e           win_c;
    logic              any_c;
    logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;

    mem_arb_pick u_pick (
        .if_req_i (bus.if_req),
        .d_req_i  (bus.d_req),
        .ptr_i    (ptr_c),
        .any_c_o  (any_c),
        .win_c_o  (win_c)
    );

`ifdef MEM_ARB_RR_EN
    req_id_e ptr_q, ptr_d;

    assign ptr_c = ptr_q;

    // Pointer names the requester that wins the next tie; it moves only on a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && any_c) begin
            ptr_d = other_id(win_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ID_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr_c = ID_D;
`endif

    // Outputs are computed for the upcoming state so they register in step with it.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d = ACCESS;
                    id_d    = win_c;
                    if (win_c == ID_D) begin
                        mem_rd_d    = !bus.d_we;
                        mem_wr_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_rd_d    = 1'b1;
                        mem_addr_d  = bus.if_addr;
                    end
                end
            end
            ACCESS: begin
                state_d  = RESP;
                if_ack_d = (id_q == ID_IF);
                d_ack_d  = (id_q == ID_D);
                if (mem_rd_q) begin
                    if (id_q == ID_IF) begin
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d  = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= ID_IF;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW    = ADDR_W_DEF;
    localparam int unsigned DW    = DATA_W_DEF;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic preload;

    mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 7 + 5);
    endfunction

    // Single-port memory with combinational read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    int n_checks = 0;
    int n_errors = 0;

    // Model state: one transaction granted at edge g occupies edges g..g+2.
    int unsigned   cyc = 0;
    int unsigned   free_edge = 0;
    int unsigned   g = 0;
    bit            inflight = 1'b0;
    req_id_e       m_id = ID_IF;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] if_rd_m = '0;
    logic [DW-1:0] d_rd_m = '0;
`ifdef MEM_ARB_RR_EN
    req_id_e       ptr_m = ID_D;
`endif

    bit            e_if_ack, e_d_ack, e_rd, e_wr, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    // Advance the model across the next rising edge using the inputs now applied.
    task automatic model_edge();
        req_id_e w;
        cyc++;
        if (inflight && cyc == g + 1 && m_we) mem_m[m_addr] = m_wdata;
        if (rst) begin
            inflight  = 1'b0;
            if_rd_m   = '0;
            d_rd_m    = '0;
            free_edge = cyc + 1;
`ifdef MEM_ARB_RR_EN
            ptr_m     = ID_D;
`endif
        end else begin
            if (inflight && cyc == g + 1 && !m_we) begin
                if (m_id == ID_IF) if_rd_m = mem_m[m_addr];
                else               d_rd_m  = mem_m[m_addr];
            end
            if (cyc >= free_edge && (bus.if_req || bus.d_req)) begin
                if (bus.if_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
                    w = ptr_m;
`else
                    w = ID_D;
`endif
                end else begin
                    w = bus.d_req ? ID_D : ID_IF;
                end
                inflight = 1'b1;
                g        = cyc;
                m_id     = w;
                if (w == ID_D) begin
                    m_we    = bus.d_we;
                    m_addr  = bus.d_addr;
                    m_wdata = bus.d_wdata;
                end else begin
                    m_we    = 1'b0;
                    m_addr  = bus.if_addr;
                    m_wdata = '0;
                end
                free_edge = cyc + 3;
`ifdef MEM_ARB_RR_EN
                ptr_m = (w == ID_D) ? ID_IF : ID_D;
`endif
            end
        end
        e_busy   = inflight && (cyc <= g + 1);
        e_rd     = inflight && (cyc == g) && !m_we;
        e_wr     = inflight && (cyc == g) && m_we;
        e_addr   = (inflight && cyc == g) ? m_addr : '0;
        e_wdata  = (inflight && cyc == g) ? m_wdata : '0;
        e_if_ack = inflight && (cyc == g + 1) && (m_id == ID_IF);
        e_d_ack  = inflight && (cyc == g + 1) && (m_id == ID_D);
    endtask

    task automatic compare();
        check_eq("if_ack",    32'(bus.if_ack),    32'(e_if_ack));
        check_eq("d_ack",     32'(bus.d_ack),     32'(e_d_ack));
        check_eq("mem_rd",    32'(bus.mem_rd),    32'(e_rd));
        check_eq("mem_wr",    32'(bus.mem_wr),    32'(e_wr));
        check_eq("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        check_eq("busy",      32'(bus.busy),      32'(e_busy));
        check_eq("if_rdata",  32'(bus.if_rdata),  32'(if_rd_m));
        check_eq("d_rdata",   32'(bus.d_rdata),   32'(d_rd_m));
        check_eq("rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 32'(0));
        check_eq("ack_excl",   32'(bus.if_ack & bus.d_ack),  32'(0));
        check_eq("ack_in_resp", 32'((bus.if_ack | bus.d_ack) & ~bus.busy), 32'(0));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [3:0] order;
        int         nd, ni, nacks;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = init_val(i);
        rst         = 1'b1;
        preload     = 1'b1;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        @(negedge clk);
        tick();
        tick();
        preload = 1'b0;
        rst     = 1'b0;

        // Fetch read of a preloaded word.
        bus.if_req = 1'b1; bus.if_addr = AW'(1);
        tick();
        check_eq("fetch_rd_access", 32'(bus.mem_rd), 32'(1));
        tick();
        check_eq("fetch_ack",   32'(bus.if_ack),   32'(1));
        check_eq("fetch_rdata", 32'(bus.if_rdata), 32'(8'h0C));
        check_eq("fetch_no_dack", 32'(bus.d_ack),  32'(0));
        bus.if_req = 1'b0;
        tick();

        // Data write then fetch read-back of the same word.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = AW'(8); bus.d_wdata = DW'(8'h06);
        tick();
        check_eq("wr_mem_wr",    32'(bus.mem_wr),    32'(1));
        check_eq("wr_mem_addr",  32'(bus.mem_addr),  32'(8));
        check_eq("wr_mem_wdata", 32'(bus.mem_wdata), 32'(8'h06));
        tick();
        check_eq("wr_dack", 32'(bus.d_ack), 32'(1));
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        bus.if_req = 1'b1; bus.if_addr = AW'(8);
        tick();
        tick();
        check_eq("readback", 32'(bus.if_rdata), 32'(8'h06));
        bus.if_req = 1'b0;
        tick();

        // Address changed mid-access, then a back-to-back request.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(13);
        tick();
        check_eq("hold_addr13", 32'(bus.mem_addr), 32'(13));
        bus.d_addr = AW'(5);
        tick();
        check_eq("hold_ack1",  32'(bus.d_ack),   32'(1));
        check_eq("hold_rdata", 32'(bus.d_rdata), 32'(8'h60));
        tick();
        tick();
        check_eq("b2b_addr5", 32'(bus.mem_addr), 32'(5));
        tick();
        check_eq("b2b_ack2",  32'(bus.d_ack),   32'(1));
        check_eq("b2b_rdata", 32'(bus.d_rdata), 32'(8'h28));
        bus.d_req = 1'b0;
        tick();

        // Reset during the access cycle of a write.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = AW'(20); bus.d_wdata = DW'(8'hA5);
        tick();
        check_eq("abort_wr_access", 32'(bus.mem_wr), 32'(1));
        rst = 1'b1; bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        check_eq("abort_busy",  32'(bus.busy),  32'(0));
        check_eq("abort_dack",  32'(bus.d_ack), 32'(0));
        check_eq("abort_addr",  32'(bus.mem_addr), 32'(0));
        rst = 1'b0;
        tick();

        // Both ports held high after reset for 12 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = AW'(3);
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(4);
        order = '0; nd = 0; ni = 0; nacks = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.d_ack) begin
                if (nacks < 4) order[nacks] = 1'b1;
                nd++; nacks++;
            end
            if (bus.if_ack) begin
                if (nacks < 4) order[nacks] = 1'b0;
                ni++; nacks++;
            end
        end
`ifdef MEM_ARB_RR_EN
        check_eq("tie_d_acks",  32'(nd),    32'(2));
        check_eq("tie_if_acks", 32'(ni),    32'(2));
        check_eq("tie_order",   32'(order), 32'(4'b0101));
`else
        check_eq("tie_d_acks",  32'(nd),    32'(4));
        check_eq("tie_if_acks", 32'(ni),    32'(0));
        check_eq("tie_order",   32'(order), 32'(4'b1111));
`endif
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tick();

        // Random traffic; requesters hold until acked, may reissue right after.
        for (int n = 0; n < 3000; n++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 59) == 0) rst = 1'b1;
            if (bus.if_req) begin
                if (e_if_ack) begin
                    if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
                    else bus.if_addr = rand_addr();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = rand_addr();
            end
            if (bus.d_req) begin
                if (e_d_ack) begin
                    if ($urandom_range(0, 1) == 0) bus.d_req = 1'b0;
                    else begin
                        bus.d_we    = 1'($urandom_range(0, 1));
                        bus.d_addr  = rand_addr();
                        bus.d_wdata = DW'($urandom);
                    end
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = rand_addr();
                bus.d_wdata = DW'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
